put_module: RTL and testbench

- Write-side handshake between a streaming IPPro core and its downstream output FIFO.
- Buffers core results in a small internal FIFO so the core only needs a registered back-pressure signal.
- Drains the buffer into the downstream FIFO whenever that FIFO is not full.
- Counterpart of the read-side GET handshake; one instance sits at each core output port.

---
 rtl/put_module.sv | 126 ++++++++++++
 tb/tb_put_module.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/put_module.sv
// ---------------------------------------------------------------------------
// put_module
//
// Write-side handshake between a streaming IPPro core and its downstream
// output FIFO. Core results are captured in a small circular buffer. The
// buffer drains into the downstream FIFO whenever that FIFO is not full.
// The core is throttled with a registered STALL so that it never has to
// react combinationally to the downstream FULL flag.
//
// Parameters
//   DATA_WIDTH : width of a core result / FIFO data word
//   DEPTH      : number of buffer entries (power of two, >= 2)
//   CNT_WIDTH  : width of COUNT, log2(DEPTH)+1
//
// Ports
//   CLK            in   system clock, all state on the rising edge
//   RESET          in   asynchronous active-low reset
//   ENABLE         in   core presents a valid result on DATA_IN
//   DATA_IN        in   core result word
//   FULL           in   downstream FIFO full flag
//   FIFO_WRITE_EN  out  write strobe to the downstream FIFO
//   FIFO_DATA_OUT  out  head-of-buffer word to the downstream FIFO
//   STALL          out  registered back-pressure to the core
//   COUNT          out  current buffer occupancy, 0..DEPTH
//   OVERFLOW       out  sticky flag, set when a result had to be dropped
// ---------------------------------------------------------------------------
module put_module #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  FULL,
  output logic                  FIFO_WRITE_EN,
  output logic [DATA_WIDTH-1:0] FIFO_DATA_OUT,
  output logic                  STALL,
  output logic [CNT_WIDTH-1:0]  COUNT,
  output logic                  OVERFLOW
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C     = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] STALL_LEVEL = CNT_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] memQ [DEPTH];

  logic [PTR_W-1:0]     wrPtrQ, wrPtrD;
  logic [PTR_W-1:0]     rdPtrQ, rdPtrD;
  logic [CNT_WIDTH-1:0] countQ, countD;
  logic                 stallQ, stallD;
  logic                 overflowQ, overflowD;

  logic popNow;
  logic pushNow;
  logic dropNow;

  // Handshake decisions for this cycle. A pop frees a slot in the same cycle,
  // so a push is still accepted when the buffer is full but draining.
  always_comb begin
    popNow  = ~FULL & (countQ != '0);
    pushNow = ENABLE & ((countQ < DEPTH_C) | popNow);
    dropNow = ENABLE & ~pushNow;
  end

  // Next-state for pointers, occupancy and flags. Pointers are exactly
  // log2(DEPTH) bits so they wrap on their own. STALL looks at the next
  // occupancy: asserting it one slot early leaves room for the result the
  // core issues before it sees the registered STALL.
  always_comb begin
    wrPtrD    = wrPtrQ;
    rdPtrD    = rdPtrQ;
    countD    = countQ;
    overflowD = overflowQ | dropNow;

    if (pushNow) begin
      wrPtrD = wrPtrQ + PTR_W'(1);
    end
    if (popNow) begin
      rdPtrD = rdPtrQ + PTR_W'(1);
    end

    case ({pushNow, popNow})
      2'b10:   countD = countQ + CNT_WIDTH'(1);
      2'b01:   countD = countQ - CNT_WIDTH'(1);
      default: countD = countQ;
    endcase

    stallD = (countD >= STALL_LEVEL);
  end

  // Control state, cleared asynchronously. Buffered data is abandoned by
  // simply resetting the pointers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      countQ    <= '0;
      stallQ    <= 1'b0;
      overflowQ <= 1'b0;
    end else begin
      wrPtrQ    <= wrPtrD;
      rdPtrQ    <= rdPtrD;
      countQ    <= countD;
      stallQ    <= stallD;
      overflowQ <= overflowD;
    end
  end

  // Buffer storage has no reset; its contents only matter between the
  // pointers, which are themselves reset.
  always_ff @(posedge CLK) begin
    if (pushNow) begin
      memQ[wrPtrQ] <= DATA_IN;
    end
  end

  assign FIFO_WRITE_EN = popNow;
  assign FIFO_DATA_OUT = memQ[rdPtrQ];
  assign STALL         = stallQ;
  assign COUNT         = countQ;
  assign OVERFLOW      = overflowQ;

endmodule

// File: tb/tb_put_module.sv
// ---------------------------------------------------------------------------
// tb_put_module
//
// Self-checking bench for put_module. A behavioural model tracks buffer
// occupancy as a plain integer and the accepted words as a queue. Every
// accepted word is pushed onto the scoreboard queue by the stimulus process.
// A separate monitor pops that queue whenever the DUT strobes FIFO_WRITE_EN
// and compares the data.
// ---------------------------------------------------------------------------
module tb_put_module;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          CLK;
  logic          RESET;
  logic          ENABLE;
  logic [DW-1:0] DATA_IN;
  logic          FULL;
  logic          FIFO_WRITE_EN;
  logic [DW-1:0] FIFO_DATA_OUT;
  logic          STALL;
  logic [CW-1:0] COUNT;
  logic          OVERFLOW;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: occupancy, sticky overflow, stall flag and the
  // queue of words still owed to the downstream FIFO.
  int          modelCount = 0;
  bit          modelStall = 0;
  bit          modelOvf   = 0;
  logic [DW-1:0] sbQ[$];

  put_module #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CW)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ENABLE       (ENABLE),
    .DATA_IN      (DATA_IN),
    .FULL         (FULL),
    .FIFO_WRITE_EN(FIFO_WRITE_EN),
    .FIFO_DATA_OUT(FIFO_DATA_OUT),
    .STALL        (STALL),
    .COUNT        (COUNT),
    .OVERFLOW     (OVERFLOW)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single comparison helper.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all registered and combinational outputs against the model.
  task automatic checkState(input string tag);
    checkOutput({tag, " COUNT"},    32'(COUNT),         32'(modelCount));
    checkOutput({tag, " STALL"},    32'(STALL),         32'(modelStall));
    checkOutput({tag, " OVERFLOW"}, 32'(OVERFLOW),      32'(modelOvf));
    checkOutput({tag, " WRITE_EN"}, 32'(FIFO_WRITE_EN),
                32'((!FULL) && (modelCount != 0)));
  endtask

  // Drive one cycle of inputs (called just after a rising edge), check the
  // outputs, advance the model, then wait for the next rising edge.
  task automatic applyStimulus(input string tag, input bit en,
                               input logic [DW-1:0] data, input bit full);
    bit popM;
    ENABLE  = en;
    DATA_IN = data;
    FULL    = full;
    #1;
    checkState(tag);
    popM = !full && (modelCount != 0);
    if (en) begin
      if (modelCount < DEPTH || popM) begin
        sbQ.push_back(data);
        modelCount++;
      end else begin
        modelOvf = 1;
      end
    end
    if (popM) modelCount--;
    modelStall = (modelCount >= DEPTH - 1);
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs must clear before any edge.
  task automatic pulseReset(input string tag);
    RESET   = 1'b0;
    ENABLE  = 1'($urandom);
    FULL    = 1'($urandom);
    DATA_IN = DW'($urandom);
    #1;
    sbQ.delete();
    modelCount = 0;
    modelStall = 0;
    modelOvf   = 0;
    checkOutput({tag, " COUNT"},    32'(COUNT),         32'd0);
    checkOutput({tag, " STALL"},    32'(STALL),         32'd0);
    checkOutput({tag, " OVERFLOW"}, 32'(OVERFLOW),      32'd0);
    checkOutput({tag, " WRITE_EN"}, 32'(FIFO_WRITE_EN), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  // Monitor: on every falling edge, a write strobe must match the oldest
  // word owed by the scoreboard.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET && FIFO_WRITE_EN) begin
        checks++;
        if (sbQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected write: got 0x%0h with nothing pending at %0t",
                   FIFO_DATA_OUT, $time);
        end else begin
          logic [DW-1:0] expW;
          expW = sbQ.pop_front();
          if (FIFO_DATA_OUT !== expW) begin
            failures++;
            $display("[TB] FAIL data order: got 0x%0h expected 0x%0h at %0t",
                     FIFO_DATA_OUT, expW, $time);
          end
        end
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int word;
    int cyc;

    RESET   = 1'b0;
    ENABLE  = 1'b1;
    FULL    = 1'b0;
    DATA_IN = 16'h1234;
    #3;
    checkOutput("reset COUNT",    32'(COUNT),         32'd0);
    checkOutput("reset STALL",    32'(STALL),         32'd0);
    checkOutput("reset OVERFLOW", 32'(OVERFLOW),      32'd0);
    checkOutput("reset WRITE_EN", 32'(FIFO_WRITE_EN), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    // Single word passes through with one cycle of latency.
    applyStimulus("single push", 1'b1, 16'h00A5, 1'b0);
    applyStimulus("single out",  1'b0, 16'h0000, 1'b0);
    applyStimulus("single idle", 1'b0, 16'h0000, 1'b0);

    // Fill against back-pressure, then push while draining at full.
    for (int i = 1; i <= 4; i++) applyStimulus("fill", 1'b1, DW'(i), 1'b1);
    applyStimulus("fill held", 1'b0, 16'h0000, 1'b1);
    applyStimulus("push+pop at full", 1'b1, 16'h0005, 1'b0);

    // Drop at full while downstream is blocked; sticky flag expected.
    applyStimulus("overflow", 1'b1, 16'h00FF, 1'b1);
    applyStimulus("overflow held", 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus("drain", 1'b0, 16'h0000, 1'b0);

    pulseReset("reset clears overflow");

    // Ten words with FULL toggling every 3 cycles, crossing pointer wrap.
    word = 1;
    cyc  = 0;
    while (word <= 10 && cyc < 200) begin
      bit fullNow;
      bit issue;
      fullNow = ((cyc / 3) % 2) == 1;
      issue   = (modelCount < DEPTH);
      applyStimulus("wrap stream", issue, DW'(word), fullNow);
      if (issue) word++;
      cyc++;
    end
    checkOutput("wrap words issued", 32'(word), 32'd11);
    for (int i = 0; i < 6; i++) applyStimulus("wrap drain", 1'b0, 16'h0000, 1'b0);
    checkOutput("wrap drained", 32'(sbQ.size()), 32'd0);

    // Mid-stream reset discards buffered words; nothing may be written after.
    applyStimulus("pre-reset push", 1'b1, 16'h0AAA, 1'b1);
    applyStimulus("pre-reset push", 1'b1, 16'h0BBB, 1'b1);
    pulseReset("mid-stream reset");
    for (int i = 0; i < 4; i++) applyStimulus("post reset idle", 1'b0, 16'h0000, 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("random", 1'($urandom_range(0, 99) < 60), DW'($urandom),
                    1'($urandom_range(0, 99) < 40));
    end
    for (int i = 0; i < 8; i++) applyStimulus("final drain", 1'b0, 16'h0000, 1'b0);
    checkOutput("final drained", 32'(sbQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
